// File: rtl/bomb_pkg.sv
// Shared types and constants for the bomb countdown timer.
//   state_t : FSM state encoding, also driven out on the 3-bit state port
//   bcd_t   : one BCD digit
//   SEC_TENS_MAX / DIGIT_MAX : wrap values used by the BCD borrow chain
package bomb_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RUNNING  = 3'd1,
    PAUSED   = 3'd2,
    DEFUSED  = 3'd3,
    EXPLODED = 3'd4
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t SEC_TENS_MAX = 4'd5;
  localparam bcd_t DIGIT_MAX    = 4'd9;

endpackage

// File: rtl/bomb_tick_prescaler.sv
// One-second tick prescaler for the bomb countdown timer.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   en    : count enable (high while the timer is running)
//   clr   : synchronous clear of the count (on arm)
//   tick  : high on the cycle the count sits at TICK_DIV-1 while enabled
// The count wraps to 0 after the tick and holds whenever en is low.
module bomb_tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign tick = en && (count == LAST);

endmodule

// File: rtl/bomb_countdown_timer.sv
// Bomb countdown timer: MM:SS BCD countdown from INIT_MIN:INIT_SEC to 00:00
// with arm / pause / disarm control and an explode indication.
//   clk, rst_n        : system clock, asynchronous active-low reset
//   arm               : pulse, load INIT value and start (from IDLE/DEFUSED/EXPLODED)
//   pause             : pulse, toggle RUNNING <-> PAUSED
//   disarm            : pulse, defuse from RUNNING/PAUSED, digits freeze
//   wrong_code        : pulse, 10 s penalty (only when BOMB_PENALTY_EN is defined)
//   min_tens..sec_ones: registered BCD digits
//   state             : registered FSM state (bomb_pkg encoding)
//   running, exploded : registered state decodes
// Build option: define BOMB_PENALTY_EN to enable the wrong_code penalty;
// without it wrong_code is ignored and no penalty logic exists.
//
// state    | meaning
// IDLE     | after reset, waiting for arm
// RUNNING  | counting down, prescaler enabled
// PAUSED   | digits and prescaler frozen
// DEFUSED  | disarmed, digits frozen at the defuse value
// EXPLODED | time ran out, digits at 00:00
module bomb_countdown_timer
  import bomb_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int INIT_MIN = 5,
  parameter int INIT_SEC = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       arm,
  input  logic       pause,
  input  logic       disarm,
  input  logic       wrong_code,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [2:0] state,
  output logic       running,
  output logic       exploded
);

  localparam bcd_t INIT_MT   = bcd_t'(INIT_MIN / 10);
  localparam bcd_t INIT_MO   = bcd_t'(INIT_MIN % 10);
  localparam bcd_t INIT_ST   = bcd_t'(INIT_SEC / 10);
  localparam bcd_t INIT_SO   = bcd_t'(INIT_SEC % 10);
  localparam bit   INIT_ZERO = (INIT_MIN == 0) && (INIT_SEC == 0);

  state_t state_q, state_d;
  bcd_t   mt_q, mo_q, st_q, so_q;
  bcd_t   mt_d, mo_d, st_d, so_d;
  logic   running_q, exploded_q;
  logic   tick, pre_en, pre_clr, at_last_sec;

  assign pre_en = (state_q == RUNNING);

  bomb_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (pre_en),
    .clr  (pre_clr),
    .tick (tick)
  );

  // 00:01 (or 00:00 defensively): the next tick ends the countdown.
  assign at_last_sec = (mt_q == 4'd0) && (mo_q == 4'd0) && (st_q == 4'd0) && (so_q <= 4'd1);

`ifdef BOMB_PENALTY_EN
  // 10 s penalty: only the tens-of-seconds digit and above move.
  logic pen_explode;
  bcd_t pen_mt, pen_mo, pen_st;

  always_comb begin
    pen_explode = (mt_q == 4'd0) && (mo_q == 4'd0) &&
                  ((st_q == 4'd0) || ((st_q == 4'd1) && (so_q == 4'd0)));
    pen_mt = mt_q;
    pen_mo = mo_q;
    pen_st = st_q;
    if (st_q != 4'd0) begin
      pen_st = st_q - 1'b1;
    end else begin
      pen_st = SEC_TENS_MAX;
      if (mo_q != 4'd0) begin
        pen_mo = mo_q - 1'b1;
      end else begin
        pen_mo = DIGIT_MAX;
        pen_mt = mt_q - 1'b1;
      end
    end
  end
`else
  logic unused_wrong_code;
  assign unused_wrong_code = wrong_code;
`endif

  always_comb begin
    state_d = state_q;
    mt_d    = mt_q;
    mo_d    = mo_q;
    st_d    = st_q;
    so_d    = so_q;
    pre_clr = 1'b0;
    case (state_q)
      IDLE, DEFUSED, EXPLODED: begin
        if (arm) begin
          pre_clr = 1'b1;
          mt_d    = INIT_MT;
          mo_d    = INIT_MO;
          st_d    = INIT_ST;
          so_d    = INIT_SO;
          state_d = INIT_ZERO ? EXPLODED : RUNNING;
        end
      end
      RUNNING, PAUSED: begin
        if (disarm) begin
          state_d = DEFUSED;
        end
`ifdef BOMB_PENALTY_EN
        else if (wrong_code) begin
          if (pen_explode) begin
            mt_d    = 4'd0;
            mo_d    = 4'd0;
            st_d    = 4'd0;
            so_d    = 4'd0;
            state_d = EXPLODED;
          end else begin
            mt_d = pen_mt;
            mo_d = pen_mo;
            st_d = pen_st;
          end
        end
`endif
        else if (pause) begin
          state_d = (state_q == RUNNING) ? PAUSED : RUNNING;
        end else if (tick) begin
          // tick can only be high in RUNNING, the prescaler is disabled otherwise
          if (at_last_sec) begin
            mt_d    = 4'd0;
            mo_d    = 4'd0;
            st_d    = 4'd0;
            so_d    = 4'd0;
            state_d = EXPLODED;
          end else if (so_q != 4'd0) begin
            so_d = so_q - 1'b1;
          end else begin
            so_d = DIGIT_MAX;
            if (st_q != 4'd0) begin
              st_d = st_q - 1'b1;
            end else begin
              st_d = SEC_TENS_MAX;
              if (mo_q != 4'd0) begin
                mo_d = mo_q - 1'b1;
              end else begin
                mo_d = DIGIT_MAX;
                mt_d = mt_q - 1'b1;
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mt_q       <= 4'd0;
      mo_q       <= 4'd0;
      st_q       <= 4'd0;
      so_q       <= 4'd0;
      running_q  <= 1'b0;
      exploded_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mt_q       <= mt_d;
      mo_q       <= mo_d;
      st_q       <= st_d;
      so_q       <= so_d;
      running_q  <= (state_d == RUNNING);
      exploded_q <= (state_d == EXPLODED);
    end
  end

  assign min_tens = mt_q;
  assign min_ones = mo_q;
  assign sec_tens = st_q;
  assign sec_ones = so_q;
  assign state    = state_q;
  assign running  = running_q;
  assign exploded = exploded_q;

endmodule
